rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
- Parametrised successor to the single-output reset synchroniser.
- Synchronises the asynchronous active-high system reset into the CLK domain through a NUM_STAGES flop chain.
- Stretches reset assertion to a guaranteed minimum length, then releases NUM_CH downstream reset outputs one at a time, STAGGER cycles apart.
- Adds a synchronous software reset request, a release-hold input, and sequence-status outputs; sits at the top of the clock domain and feeds every block's reset.

Parameters:
- NUM_STAGES, 3: synchroniser chain depth; legal range >= 2.
- NUM_CH, 4: number of sequenced reset outputs; legal range >= 1.
- MIN_ASSERT, 16: minimum CLK cycles that all outputs stay asserted after the synchronised reset goes low; legal range >= 1.
- STAGGER, 8: CLK cycles between consecutive channel releases; legal range >= 1.

Ports:
- CLK, input, 1: domain clock.
- RST, input, 1: asynchronous active-high reset; assertion is asynchronous, deassertion is synchronised internally.
- SW_RST_REQ, input, 1: synchronous software reset request, sampled on the CLK rising edge.
- HOLD, input, 1: while high, freezes the release sequence.
- SYNC_RST, output, NUM_CH: per-channel reset, active-high; bit 0 releases first.
- RST_DONE, output, 1: high once all channels are released.
- BUSY, output, 1: high while the sequence is not DONE.

Behaviour:
- Reset is asynchronous and active-high. While RST=1, immediately and asynchronously:
  - all sync flops = 1;
  - SYNC_RST = all ones;
  - RST_DONE = 0, BUSY = 1;
  - state = ASSERT, cnt = 0, idx = 0.
- Sync chain:
  - each flop is async-set by RST and shifts in 0;
  - rst_s = last stage;
  - rst_s falls on the NUM_STAGES-th rising edge after RST falls.
- FSM states are ASSERT, RELEASE and DONE.
- ASSERT:
  - if rst_s = 1, cnt is held at 0;
  - otherwise cnt increments each edge;
  - at the edge where cnt = MIN_ASSERT-1: SYNC_RST[0] <= 0, cnt <= 0, idx <= 1;
  - next state is RELEASE, or DONE if NUM_CH = 1.
- RELEASE:
  - cnt increments each edge unless HOLD = 1, in which case cnt and idx freeze;
  - at the edge where cnt = STAGGER-1: SYNC_RST[idx] <= 0, cnt <= 0, idx <= idx+1;
  - the edge that releases channel NUM_CH-1 also sets RST_DONE <= 1 and moves to DONE.
- DONE: outputs are stable; BUSY = 0.
- Release timing, with edges counted from the first rising edge after RST falls:
  - channel k deasserts at edge NUM_STAGES + MIN_ASSERT + k*STAGGER;
  - with defaults: channels at edges 19, 27, 35, 43; RST_DONE at edge 43.
- SW_RST_REQ = 1 at an edge, in any state:
  - SYNC_RST <= all ones, RST_DONE <= 0, cnt <= 0, idx <= 0, state <= ASSERT;
  - the full MIN_ASSERT stretch and stagger then rerun;
  - rst_s is already low, so channel 0 releases MIN_ASSERT edges after the last edge at which the request was sampled high;
  - holding SW_RST_REQ high keeps cnt at 0 in ASSERT.
- Simultaneous events:
  - RST overrides SW_RST_REQ and HOLD;
  - SW_RST_REQ overrides HOLD and a pending release on the same edge.
- HOLD has no effect in ASSERT or DONE.
- RST asserted mid-sequence: all outputs re-assert asynchronously within the same cycle, without waiting for an edge.
- Once deasserted, SYNC_RST bits change only on CLK edges, so they are glitch-free.
- Counter width: clog2(max(MIN_ASSERT, STAGGER)), minimum 1. idx width: clog2(NUM_CH), minimum 1.

Decomposition:
- Shared package rst_pkg holds:
  - the state encoding: ASSERT = 2'd0, RELEASE = 2'd1, DONE = 2'd2;
  - a clog2-based width helper function.
- Sub-module rst_sync_chain (parameter NUM_STAGES; ports CLK, RST, rst_s) is instantiated once.
- The sequencer FSM, counters and output register stay in rst_sequencer.

Test Plan:
1. Defaults: RST=1 for 2 cycles, then 0, SW_RST_REQ=HOLD=0.
   - SYNC_RST = 4'b1111 through edge 18, 4'b1110 at 19, 4'b1100 at 27, 4'b1000 at 35, 4'b0000 at 43.
   - RST_DONE and BUSY change at edge 43.
2. RST pulsed high between edges while in DONE.
   - SYNC_RST = 4'b1111 and RST_DONE = 0 immediately.
   - After RST falls, the full sequence of scenario 1 repeats.
3. In DONE, SW_RST_REQ high for exactly one edge E.
   - SYNC_RST = 4'b1111 after E.
   - Channel 0 releases at E+16, channel 3 and RST_DONE at E+40.
4. HOLD=1 for 5 cycles starting right after channel 1 releases.
   - Channels 2 and 3 release 5 cycles later than in scenario 1, at edges 40 and 48.
5. RST reasserted at edge 30, mid-RELEASE.
   - Outputs return to 4'b1111 asynchronously.
   - After RST falls, release restarts from channel 0 with scenario-1 timing.
6. NUM_CH=1, MIN_ASSERT=1, NUM_STAGES=2.
   - SYNC_RST and RST_DONE both change at edge 3; BUSY = 0 from edge 3.

Source files
------------

// File: rtl/rst_pkg.sv
// rst_pkg: shared state encoding and width helper for the reset sequencer
package rst_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: async-assert, sync-deassert reset synchroniser
module rst_sync_chain #(
    parameter int NUM_STAGES = 3
) (
    input  logic CLK,
    input  logic RST,
    output logic rst_s
);

    logic [NUM_STAGES-1:0] q;

    // Every stage is set by RST and shifts in zeros once RST is gone
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            q <= '1;
        else
            q <= {q[NUM_STAGES-2:0], 1'b0};
    end

    assign rst_s = q[NUM_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: synchronised, stretched and staggered multi-channel reset release
module rst_sequencer
    import rst_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int NUM_CH     = 4,
    parameter int MIN_ASSERT = 16,
    parameter int STAGGER    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST_REQ,
    input  logic              HOLD,
    output logic [NUM_CH-1:0] SYNC_RST,
    output logic              RST_DONE,
    output logic              BUSY
);

    localparam int CW = width_of(MIN_ASSERT > STAGGER ? MIN_ASSERT : STAGGER);
    localparam int IW = width_of(NUM_CH);
    localparam logic [CW-1:0] CNT_MIN  = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] CNT_STG  = CW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);

    logic              rst_s;
    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [IW-1:0]     idx, idx_d;
    logic [NUM_CH-1:0] sync_d;
    logic              done_d;

    rst_sync_chain #(.NUM_STAGES(NUM_STAGES)) u_sync (
        .CLK   (CLK),
        .RST   (RST),
        .rst_s (rst_s)
    );

    // State, counters and outputs; RST forces everything back to fully asserted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ASSERT;
            cnt      <= '0;
            idx      <= '0;
            SYNC_RST <= '1;
            RST_DONE <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            idx      <= idx_d;
            SYNC_RST <= sync_d;
            RST_DONE <= done_d;
        end
    end

    // Stretch, then release one channel per stagger period; software request restarts
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        sync_d  = SYNC_RST;
        done_d  = RST_DONE;
        if (SW_RST_REQ) begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            sync_d  = '1;
            done_d  = 1'b0;
        end else begin
            case (state)
                ASSERT: begin
                    if (rst_s) begin
                        cnt_d = '0;
                    end else if (cnt == CNT_MIN) begin
                        sync_d[0] = 1'b0;
                        cnt_d     = '0;
                        idx_d     = IW'(1);
                        state_d   = (NUM_CH == 1) ? DONE : RELEASE;
                        done_d    = (NUM_CH == 1);
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!HOLD) begin
                        if (cnt == CNT_STG) begin
                            sync_d[idx] = 1'b0;
                            cnt_d       = '0;
                            idx_d       = idx + IW'(1);
                            state_d     = (idx == IDX_LAST) ? DONE : RELEASE;
                            done_d      = (idx == IDX_LAST);
                        end else begin
                            cnt_d = cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state != DONE);

endmodule
